// File: rtl/axil_slave_read_ctrl.sv
// AXI4-Lite read-channel slave bridging AR/R to a simple user register port.
// Decodes a base/range window (DECERR on miss), bounds the wait on the user
// port with a timeout (SLVERR plus abort pulse) and counts error responses.
module axil_slave_read_ctrl #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter longint unsigned       ADDR_RANGE     = 4096,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  S_AXIL_ACLK,
  input  logic                  S_AXIL_ARESET,
  input  logic                  S_AXIL_ARVALID,
  output logic                  S_AXIL_ARREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXIL_ARADDR,
  input  logic [2:0]            S_AXIL_ARPROT,
  output logic                  S_AXIL_RVALID,
  input  logic                  S_AXIL_RREADY,
  output logic [DATA_WIDTH-1:0] S_AXIL_RDATA,
  output logic [1:0]            S_AXIL_RRESP,
  output logic                  user_port_arvalid,
  input  logic                  user_port_arready,
  output logic [ADDR_WIDTH-1:0] user_port_araddr,
  output logic [2:0]            user_port_arprot,
  input  logic                  user_port_rvalid,
  input  logic [DATA_WIDTH-1:0] user_port_rdata,
  input  logic [1:0]            user_port_rresp,
  output logic                  user_port_abort,
  output logic [15:0]           rd_err_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK  = ~ADDR_WIDTH'(ADDR_RANGE - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {IDLE, UREQ, UDATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] uaddr_q, uaddr_d;
  logic [2:0]            uprot_q, uprot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  abort_q, abort_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic ar_hs, addr_hit, waiting, u_data, tmo_hit, r_hs;

  // Handshake and decode qualifiers shared by the FSM and datapath
  always_comb begin
    ar_hs    = S_AXIL_ARVALID & arready_q;
    addr_hit = (S_AXIL_ARADDR & WIN_MASK) == BASE_ADDR;
    waiting  = (state_q == UREQ) | (state_q == UDATA);
    // Data is only accepted once the request itself has been taken
    u_data   = ((state_q == UREQ) & user_port_arready & user_port_rvalid) |
               ((state_q == UDATA) & user_port_rvalid);
    tmo_hit  = TMO_EN & waiting & (tmo_cnt_q == TMO_LAST);
    r_hs     = (state_q == RESP) & S_AXIL_RREADY;
  end

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge S_AXIL_ACLK or posedge S_AXIL_ARESET) begin
    if (S_AXIL_ARESET) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      uaddr_q   <= '0;
      uprot_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      abort_q   <= 1'b0;
      tmo_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      uaddr_q   <= uaddr_d;
      uprot_q   <= uprot_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      abort_q   <= abort_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state logic; arrival of data takes priority over the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ar_hs) state_d = addr_hit ? UREQ : RESP;
      UREQ: begin
        if (u_data || tmo_hit)      state_d = RESP;
        else if (user_port_arready) state_d = UDATA;
      end
      UDATA: if (u_data || tmo_hit) state_d = RESP;
      RESP:  if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: request latch, response capture, timeout and error count
  always_comb begin
    arready_d = (state_d == IDLE);
    uaddr_d   = uaddr_q;
    uprot_d   = uprot_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    abort_d   = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ar_hs) begin
      uaddr_d   = (S_AXIL_ARADDR - BASE_ADDR) & WORD_MASK;
      uprot_d   = S_AXIL_ARPROT;
      rdata_d   = '0;
      rresp_d   = addr_hit ? RESP_OKAY : RESP_DECERR;
      tmo_cnt_d = '0;
    end else if (waiting) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (u_data) begin
        rdata_d = user_port_rdata;
        rresp_d = user_port_rresp;
      end else if (tmo_hit) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        abort_d = 1'b1;
      end
    end
    if (r_hs && (rresp_q != RESP_OKAY) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Bus-facing outputs decoded from state and registers
  always_comb begin
    S_AXIL_ARREADY    = arready_q;
    S_AXIL_RVALID     = (state_q == RESP);
    S_AXIL_RDATA      = rdata_q;
    S_AXIL_RRESP      = rresp_q;
    user_port_arvalid = (state_q == UREQ);
    user_port_araddr  = uaddr_q;
    user_port_arprot  = uprot_q;
    user_port_abort   = abort_q;
    rd_err_count      = err_cnt_q;
  end

endmodule

// File: tb/tb_axil_slave_read_ctrl.sv
// Directed bench for axil_slave_read_ctrl: a 32-bit instance with an 8-cycle
// timeout and a 64-bit instance for wide-data address alignment.
module tb_axil_slave_read_ctrl;

  localparam logic [31:0] BASE_A = 32'h4000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 32-bit data, 4 KiB window, timeout 8
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] araddr = '0, rdata;
  logic [2:0]  arprot = '0;
  logic [1:0]  rresp;
  logic        u_arvalid, u_arready = 0, u_rvalid = 0, u_abort;
  logic [31:0] u_araddr, u_rdata = '0;
  logic [2:0]  u_arprot;
  logic [1:0]  u_rresp = '0;
  logic [15:0] err_cnt;

  // Instance B: 64-bit data, 256-byte window
  logic        arvalid_b = 0, arready_b, rvalid_b, rready_b = 0;
  logic [31:0] araddr_b = '0;
  logic [63:0] rdata_b;
  logic [1:0]  rresp_b;
  logic        u_arvalid_b, u_arready_b = 0, u_rvalid_b = 0, u_abort_b;
  logic [31:0] u_araddr_b;
  logic [63:0] u_rdata_b = '0;
  logic [2:0]  u_arprot_b;
  logic [15:0] err_cnt_b;

  axil_slave_read_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE_A),
    .ADDR_RANGE(4096), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .S_AXIL_ACLK(clk), .S_AXIL_ARESET(rst),
    .S_AXIL_ARVALID(arvalid), .S_AXIL_ARREADY(arready),
    .S_AXIL_ARADDR(araddr), .S_AXIL_ARPROT(arprot),
    .S_AXIL_RVALID(rvalid), .S_AXIL_RREADY(rready),
    .S_AXIL_RDATA(rdata), .S_AXIL_RRESP(rresp),
    .user_port_arvalid(u_arvalid), .user_port_arready(u_arready),
    .user_port_araddr(u_araddr), .user_port_arprot(u_arprot),
    .user_port_rvalid(u_rvalid), .user_port_rdata(u_rdata),
    .user_port_rresp(u_rresp), .user_port_abort(u_abort),
    .rd_err_count(err_cnt)
  );

  axil_slave_read_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BASE_ADDR(BASE_B),
    .ADDR_RANGE(256), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .S_AXIL_ACLK(clk), .S_AXIL_ARESET(rst),
    .S_AXIL_ARVALID(arvalid_b), .S_AXIL_ARREADY(arready_b),
    .S_AXIL_ARADDR(araddr_b), .S_AXIL_ARPROT(3'b000),
    .S_AXIL_RVALID(rvalid_b), .S_AXIL_RREADY(rready_b),
    .S_AXIL_RDATA(rdata_b), .S_AXIL_RRESP(rresp_b),
    .user_port_arvalid(u_arvalid_b), .user_port_arready(u_arready_b),
    .user_port_araddr(u_araddr_b), .user_port_arprot(u_arprot_b),
    .user_port_rvalid(u_rvalid_b), .user_port_rdata(u_rdata_b),
    .user_port_rresp(2'b00), .user_port_abort(u_abort_b),
    .rd_err_count(err_cnt_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_uarvalid", u_arvalid, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_abort", u_abort, 0);
    rst = 0;
    chk("rel_arready_pre", arready, 0);
    tick();
    chk("rel_arready_post", arready, 1);

    // Hit read: device takes request, data one cycle after
    arvalid = 1; araddr = BASE_A + 32'h10; arprot = 3'b010; rready = 1;
    tick();
    arvalid = 0;
    chk("t1_arready_drop", arready, 0);
    chk("t1_uarvalid", u_arvalid, 1);
    chk("t1_uaraddr", u_araddr, 32'h10);
    chk("t1_uarprot", u_arprot, 3'b010);
    u_arready = 1;
    tick();
    u_arready = 0;
    chk("t1_uarvalid_drop", u_arvalid, 0);
    chk("t1_rvalid_wait", rvalid, 0);
    u_rvalid = 1; u_rdata = 32'hDEADBEEF; u_rresp = 2'd0;
    tick();
    u_rvalid = 0;
    chk("t1_rvalid", rvalid, 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_rresp", rresp, 0);
    tick();
    chk("t1_rvalid_low", rvalid, 0);
    chk("t1_arready_back", arready, 1);
    chk("t1_errcnt", err_cnt, 0);

    // Miss: one past the window gives DECERR without touching the user port
    arvalid = 1; araddr = BASE_A + 32'h1000;
    tick();
    arvalid = 0;
    chk("t2_rvalid", rvalid, 1);
    chk("t2_rresp", rresp, 3);
    chk("t2_rdata", rdata, 0);
    chk("t2_uarvalid", u_arvalid, 0);
    tick();
    chk("t2_rvalid_low", rvalid, 0);
    chk("t2_errcnt", err_cnt, 1);
    chk("t2_uarvalid_after", u_arvalid, 0);

    // Timeout: request taken, data never arrives within 8 cycles
    arvalid = 1; araddr = BASE_A + 32'h20;
    tick();
    arvalid = 0; u_arready = 1;
    chk("t3_uarvalid", u_arvalid, 1);
    tick();
    u_arready = 0;
    chk("t3_rvalid_c1", rvalid, 0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk($sformatf("t3_rvalid_c%0d", k), rvalid, 0);
      chk($sformatf("t3_abort_c%0d", k), u_abort, 0);
    end
    tick();
    chk("t3_rvalid_tmo", rvalid, 1);
    chk("t3_rresp_tmo", rresp, 2);
    chk("t3_rdata_tmo", rdata, 0);
    chk("t3_abort_pulse", u_abort, 1);
    chk("t3_uarvalid_tmo", u_arvalid, 0);
    u_rvalid = 1; u_rdata = 32'hBAD0BAD0;
    tick();
    chk("t3_abort_end", u_abort, 0);
    chk("t3_rvalid_low", rvalid, 0);
    chk("t3_errcnt", err_cnt, 2);
    tick();
    chk("t3_late_ignored", rvalid, 0);
    chk("t3_late_arready", arready, 1);
    u_rvalid = 0;
    // Follow-up read with request and data in the same cycle
    arvalid = 1; araddr = BASE_A + 32'h30;
    tick();
    arvalid = 0; u_arready = 1; u_rvalid = 1; u_rdata = 32'h12345678; u_rresp = 2'd0;
    tick();
    u_arready = 0; u_rvalid = 0;
    chk("t3b_rvalid", rvalid, 1);
    chk("t3b_rdata", rdata, 32'h12345678);
    chk("t3b_uaraddr", u_araddr, 32'h30);
    tick();
    chk("t3b_rvalid_low", rvalid, 0);
    chk("t3b_errcnt", err_cnt, 2);

    // Back-pressure in RESP with a device SLVERR; a new AR is held meanwhile
    rready = 0;
    arvalid = 1; araddr = BASE_A + 32'h44;
    tick();
    araddr = BASE_A + 32'h2000;
    u_arready = 1; u_rvalid = 1; u_rdata = 32'hCAFEF00D; u_rresp = 2'd2;
    tick();
    u_arready = 0; u_rvalid = 0; u_rdata = 32'hFFFFFFFF; u_rresp = 2'd0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_rvalid_%0d", i), rvalid, 1);
      chk($sformatf("t4_rdata_%0d", i), rdata, 32'hCAFEF00D);
      chk($sformatf("t4_rresp_%0d", i), rresp, 2);
      chk($sformatf("t4_arready_%0d", i), arready, 0);
      tick();
    end
    chk("t4_rvalid_held", rvalid, 1);
    rready = 1;
    tick();
    chk("t4_rvalid_low", rvalid, 0);
    chk("t4_arready_back", arready, 1);
    chk("t4_errcnt", err_cnt, 3);
    tick();
    arvalid = 0;
    chk("t4_held_rvalid", rvalid, 1);
    chk("t4_held_rresp", rresp, 3);
    chk("t4_held_uarvalid", u_arvalid, 0);
    tick();
    chk("t4_held_errcnt", err_cnt, 4);

    // Reset asserted while waiting for device data
    arvalid = 1; araddr = BASE_A + 32'h50;
    tick();
    arvalid = 0; u_arready = 1;
    tick();
    u_arready = 0;
    chk("t6_rvalid_udata", rvalid, 0);
    #2;
    rst = 1;
    #1;
    chk("t6_arready_rst", arready, 0);
    chk("t6_rvalid_rst", rvalid, 0);
    chk("t6_uarvalid_rst", u_arvalid, 0);
    chk("t6_uaraddr_rst", u_araddr, 0);
    chk("t6_errcnt_rst", err_cnt, 0);
    tick();
    rst = 0;
    u_rvalid = 1; u_rdata = 32'h55AA55AA;
    chk("t6_arready_rel", arready, 0);
    tick();
    u_rvalid = 0;
    chk("t6_arready_edge", arready, 1);
    chk("t6_no_rbeat", rvalid, 0);
    tick();
    chk("t6_no_rbeat2", rvalid, 0);

    // 64-bit instance: unaligned address rounds down to the 8-byte word
    arvalid_b = 1; araddr_b = BASE_B + 32'h0C;
    tick();
    arvalid_b = 0;
    chk("t5_uaraddr", u_araddr_b, 32'h08);
    chk("t5_uarvalid", u_arvalid_b, 1);
    u_arready_b = 1;
    tick();
    u_arready_b = 0; u_rvalid_b = 1; u_rdata_b = 64'h0123_4567_89AB_CDEF;
    tick();
    u_rvalid_b = 0;
    chk("t5_rvalid", rvalid_b, 1);
    chk("t5_rdata", rdata_b, 64'h0123_4567_89AB_CDEF);
    chk("t5_rresp", rresp_b, 0);
    rready_b = 1;
    tick();
    chk("t5_rvalid_low", rvalid_b, 0);
    chk("t5_arready", arready_b, 1);
    chk("t5_errcnt", err_cnt_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
